// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   localparam int REQ_CORE         = 0;
   localparam int REQ_LOAD         = 1;
   localparam int LOCK_MAX_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_lock_timer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_lock_timer
// Description : Saturating lock-hold counter; flags the last permitted locked
//               cycle so the arbiter can force the lock back to arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_lock_timer
   import dmem_arb_pkg::*;
#(
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   output logic o_timeout
);

   localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(LOCK_MAX - 1);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOCK_MAX - 2);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_run) begin
         r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // The ARB cycle that took the lock counts as the first held cycle, so the
   // counter reaching LOCK_MAX-1 on this edge means LOCK_MAX grants have gone out.
   assign o_timeout = i_run && (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester data-memory arbiter with lock and lock timeout.
//               Macro DMEM_ARB_RR_EN selects round-robin instead of fixed
//               priority in the ARB state.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_i,
   input  logic [1:0]          we_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [2*DATA_W-1:0] wdata_i,
   input  logic [7:0]          bmask_i,
   input  logic [1:0]          lock_i,
   output logic [1:0]          gnt_o,
   output logic [1:0]          rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                mem_en_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [3:0]          mem_bmask_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_prio;
   logic       w_prio_nxt;
   logic [1:0] w_gnt;
   logic [1:0] w_xfer;
   logic [1:0] r_rvalid;
   logic       w_timeout;
   logic       w_sel;

   always_comb begin
      w_gnt = 2'b00;
      case (r_state)
         ST_ARB: begin
            if (req_i == 2'b11) begin
               w_gnt = r_prio ? 2'b10 : 2'b01;
            end else begin
               w_gnt = req_i;
            end
         end
         ST_LOCK0: w_gnt = {1'b0, req_i[REQ_CORE]};
         ST_LOCK1: w_gnt = {req_i[REQ_LOAD], 1'b0};
         default:  w_gnt = 2'b00;
      endcase
   end

   assign w_xfer = req_i & w_gnt;

   dmem_arb_lock_timer #(
      .LOCK_MAX (LOCK_MAX)
   ) u_lock_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (r_state != ST_ARB),
      .o_timeout (w_timeout)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      case (r_state)
         ST_ARB: begin
            if (w_xfer[REQ_CORE] && lock_i[REQ_CORE]) begin
               w_state_nxt = ST_LOCK0;
            end else if (w_xfer[REQ_LOAD] && lock_i[REQ_LOAD]) begin
               w_state_nxt = ST_LOCK1;
            end
            if (|w_xfer) begin
`ifdef DMEM_ARB_RR_EN
               // Point at whoever did not just transfer.
               w_prio_nxt = w_xfer[REQ_CORE];
`else
               // A timeout hand-over lasts for one ARB transfer only.
               w_prio_nxt = 1'b0;
`endif
            end
         end
         ST_LOCK0: begin
            if (!req_i[REQ_CORE] || (w_xfer[REQ_CORE] && !lock_i[REQ_CORE]) || w_timeout) begin
               w_state_nxt = ST_ARB;
            end
            if (w_timeout) begin
               w_prio_nxt = 1'b1;
            end
         end
         ST_LOCK1: begin
            if (!req_i[REQ_LOAD] || (w_xfer[REQ_LOAD] && !lock_i[REQ_LOAD]) || w_timeout) begin
               w_state_nxt = ST_ARB;
            end
            if (w_timeout) begin
               w_prio_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_ARB;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_ARB;
         r_prio   <= 1'b0;
         r_rvalid <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_prio   <= w_prio_nxt;
         r_rvalid <= w_gnt & ~we_i;
      end
   end

   // Grant is combinational, so it is masked while reset is held.
   assign gnt_o    = w_gnt & {2{rst_n}};
   assign mem_en_o = |gnt_o;
   assign w_sel    = gnt_o[REQ_LOAD];

   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_bmask_o = 4'b0000;
      if (mem_en_o) begin
         mem_we_o    = we_i[w_sel];
         mem_addr_o  = w_sel ? addr_i[2*ADDR_W-1:ADDR_W]  : addr_i[ADDR_W-1:0];
         mem_wdata_o = w_sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
         mem_bmask_o = w_sel ? bmask_i[7:4]               : bmask_i[3:0];
      end
   end

   assign rvalid_o = r_rvalid;
   assign rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomized self-checking bench for dmem_arbiter against a
//               cycle-level ownership model; honours DMEM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 32;
   localparam int LOCK_MAX = 16;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic [1:0]          req, we, lock;
   logic [2*ADDR_W-1:0] addr;
   logic [2*DATA_W-1:0] wdata;
   logic [7:0]          bmask;
   logic [1:0]          gnt_o, rvalid_o;
   logic [DATA_W-1:0]   rdata_o, mem_wdata_o, mem_rdata;
   logic                mem_en_o, mem_we_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [3:0]          mem_bmask_o;

   logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

   int n_chk = 0;
   int n_err = 0;

   // Reference model: who owns a lock (-1 none), how many cycles it has held it,
   // which requester wins a tie, and what the next cycle's read return must be.
   int          owner = -1;
   int          held  = 0;
   int          prio  = 0;
   logic [1:0]  exp_rv = 2'b00;
   logic [31:0] exp_rd = '0;
   logic [1:0]  last_g = 2'b00;

   dmem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .LOCK_MAX (LOCK_MAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .bmask_i     (bmask),
      .lock_i      (lock),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_bmask_o (mem_bmask_o),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory; contents are re-seeded whenever reset is held.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h1234_5678;
         end
      end else if (mem_en_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_bmask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
         end else begin
            mem_rdata <= mem[mem_addr_o];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] model_gnt(input logic [1:0] r);
      if (owner >= 0) begin
         if (!r[owner]) return 2'b00;
         return (owner == 1) ? 2'b10 : 2'b01;
      end
      if (r == 2'b11) return (prio == 1) ? 2'b10 : 2'b01;
      return r;
   endfunction

   task automatic model_reset();
      owner  = -1;
      held   = 0;
      prio   = 0;
      exp_rv = 2'b00;
      last_g = 2'b00;
   endtask

   // Check one cycle against the model, advance the model, move to next negedge.
   task automatic step();
      logic [1:0] g;
      int         w;
      #1;
      g = model_gnt(req);
      w = g[1] ? 1 : 0;
      chk("gnt", gnt_o, g);
      chk("rvalid", rvalid_o, exp_rv);
      if (exp_rv != 2'b00) chk("rdata", rdata_o, exp_rd);
      chk("mem_en", mem_en_o, |g);
      if (g != 2'b00) begin
         chk("mem_we", mem_we_o, we[w]);
         chk("mem_addr", mem_addr_o, addr[w*ADDR_W +: ADDR_W]);
         chk("mem_wdata", mem_wdata_o, wdata[w*DATA_W +: DATA_W]);
         chk("mem_bmask", mem_bmask_o, bmask[w*4 +: 4]);
      end else begin
         chk("mem_idle", {mem_we_o, mem_addr_o, mem_bmask_o, mem_wdata_o}, '0);
      end
      exp_rv = g & ~we;
      exp_rd = mem[addr[w*ADDR_W +: ADDR_W]];
      if (owner < 0) begin
         if (g != 2'b00) begin
            if (lock[w]) begin
               owner = w;
               held  = 1;
            end
            prio = RR ? 1 - w : 0;
         end
      end else begin
         held++;
         if (held == LOCK_MAX) prio = 1 - owner;
         if (!req[owner] || !lock[owner] || held == LOCK_MAX) owner = -1;
      end
      last_g = g;
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [3:0] m, input logic l);
      req[i]                  = r;
      we[i]                   = w;
      addr[i*ADDR_W +: ADDR_W] = a;
      wdata[i*DATA_W +: DATA_W] = d;
      bmask[i*4 +: 4]         = m;
      lock[i]                 = l;
   endtask

   initial begin
      rst_n = 1'b0;
      req = 2'b11; we = 2'b00; lock = 2'b00;
      addr = '0; wdata = '0; bmask = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_rvalid", rvalid_o, 2'b00);
      chk("rst_mem_en", mem_en_o, 1'b0);
      @(negedge clk);

      // Both requesting from reset release: RR alternates, fixed stays on core.
      rst_n = 1'b1;
      set_req(0, 1'b1, 1'b0, 11'h020, '0, 4'hF, 1'b0);
      set_req(1, 1'b1, 1'b0, 11'h030, '0, 4'hF, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1 chk("t35_seq", gnt_o, (RR && (k % 2 == 1)) ? 2'b10 : 2'b01);
         step();
      end

      // Lone core read of the 0xDEADBEEF word.
      set_req(1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
      set_req(0, 1'b1, 1'b0, 11'h010, '0, 4'hF, 1'b0);
      #1 chk("t34_gnt", gnt_o, 2'b01);
      step();
      req = 2'b00;
      #1 chk("t34_rvalid", rvalid_o, 2'b01);
      chk("t34_rdata", rdata_o, 32'hDEADBEEF);
      step();

      // Loader write with partial byte mask, then read it back.
      set_req(1, 1'b1, 1'b1, 11'h044, 32'h55AA55AA, 4'b0011, 1'b0);
      #1 chk("t36_we", mem_we_o, 1'b1);
      chk("t36_bmask", mem_bmask_o, 4'b0011);
      step();
      set_req(1, 1'b1, 1'b0, 11'h044, '0, 4'hF, 1'b0);
      #1 chk("t36_no_rvalid", rvalid_o, 2'b00);
      step();
      req = 2'b00;
      step();

      // Loader holds a lock while the core waits: LOCK_MAX grants, then core.
      set_req(1, 1'b1, 1'b0, 11'h050, '0, 4'hF, 1'b1);
      #1 chk("t37_take", gnt_o, 2'b10);
      step();
      set_req(0, 1'b1, 1'b0, 11'h060, '0, 4'hF, 1'b0);
      for (int k = 1; k < LOCK_MAX; k++) begin
         #1 chk("t37_held", gnt_o, 2'b10);
         step();
      end
      #1 chk("t37_handover", gnt_o, 2'b01);
      step();
      req = 2'b00; lock = 2'b00;
      step();

      // Reset in the cycle after a granted read kills the rvalid.
      set_req(0, 1'b1, 1'b0, 11'h010, '0, 4'hF, 1'b0);
      step();
      req = 2'b00;
      rst_n = 1'b0;
      #1 chk("t38_rvalid", rvalid_o, 2'b00);
      chk("t38_gnt", gnt_o, 2'b00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1, 1'b1, 1'b0, 11'h010, '0, 4'hF, 1'b0);
      #1 chk("t38_first", gnt_o, 2'b10);
      step();

      // Random traffic; later phases bias towards long locks to reach timeouts.
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
               if (!(req[i] && !last_g[i])) begin
                  set_req(i,
                          $urandom_range(0, 99) < (ph == 0 ? 60 : 95),
                          $urandom_range(0, 2) == 0,
                          11'($urandom_range(0, 31)),
                          $urandom,
                          4'($urandom),
                          $urandom_range(0, 99) < (ph == 0 ? 30 : 92));
               end
            end
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width of the shared data memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter LOCK_MAX, default 16, maximum cycles one requester may hold a lock.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset on these ports: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_i  input  2  per-requester access request; bit 0 is the core LSU, bit 1 is the loader/debug port.
REQ-007 we_i  input  2  per-requester write enable.
REQ-008 addr_i  input  2xADDR_W  per-requester word address, packed.
REQ-009 wdata_i  input  2xDATA_W  per-requester write data, packed.
REQ-010 bmask_i  input  2x4  per-requester byte mask, packed.
REQ-011 lock_i  input  2  per-requester request to keep ownership after the current transfer.
REQ-012 gnt_o  output  2  per-requester grant; at most one bit is high.
REQ-013 rvalid_o  output  2  per-requester read-data valid.
REQ-014 rdata_o  output  DATA_W  shared read data.
REQ-015 mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bmask_o  output  1/1/ADDR_W/DATA_W/4  memory access, taken from the granted requester.
REQ-016 mem_rdata_i  input  DATA_W  memory read data, valid 1 cycle after mem_en_o with mem_we_o=0.

Function
REQ-017 gnt_o SHALL be combinational from req_i and the registered state; a transfer completes on the edge where req_i[i] and gnt_o[i] are both high.
REQ-018 A requester SHALL hold req, we, addr, wdata and bmask stable until it is granted; the arbiter SHALL NOT check this.
REQ-019 mem_en_o SHALL equal |gnt_o; the mem_* fields SHALL be muxed from the granted requester, and SHALL be zero when there is no grant.
REQ-020 rvalid_o[i] SHALL pulse exactly one cycle after a granted read by requester i; rdata_o SHALL pass mem_rdata_i through; writes SHALL produce no rvalid.
REQ-021 The FSM SHALL have the states ARB, LOCK0 and LOCK1.
REQ-022 In ARB, a lone requester SHALL be granted in the same cycle; when both request, the requester selected by prio_q SHALL be granted.
REQ-023 ARB SHALL go to LOCKi when requester i completes a transfer with lock_i[i]=1.
REQ-024 In LOCKi, only requester i SHALL be granted and the other SHALL wait.
REQ-025 LOCKi SHALL return to ARB when requester i completes a transfer with lock_i[i]=0, when req_i[i] is low, or when the lock counter reaches LOCK_MAX-1.
REQ-026 The lock counter SHALL increment every cycle in a LOCK state and clear in ARB; on a timeout exit, prio_q SHALL be forced to the other requester.
REQ-027 Back-to-back transfers by the same requester SHALL be allowed every cycle, giving full throughput.

Reset
REQ-028 While rst_n is low: gnt_o=0, rvalid_o=0, mem_en_o=0, state=ARB, prio_q=0, lock counter=0.
REQ-029 Reset asserted mid-transfer SHALL drop any pending rvalid; after reset release, the first grant SHALL be possible on the first clk edge.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN, when defined, SHALL make arbitration round-robin: after each completed transfer in ARB, prio_q SHALL point to the other requester.
REQ-031 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed-priority: requester 0 always wins in ARB, while lock and lock timeout still apply.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the FSM state enum, the constants REQ_CORE=0 and REQ_LOAD=1, and the default LOCK_MAX.
REQ-033 One sub-module, dmem_arb_lock_timer, SHALL implement the saturating lock counter and its timeout flag.

Verification
REQ-034 Only req_i=01, read addr 0x010 with memory word 0xDEADBEEF -> gnt_o=01 in the same cycle; rvalid_o=01 with rdata_o=0xDEADBEEF one cycle later.
REQ-035 req_i=11 held for 4 cycles with RR enabled -> grants 01,10,01,10; with the macro undefined -> grants 01,01,01,01.
REQ-036 Requester 1 writes 0x55AA55AA with bmask 0011 -> mem_we_o=1, mem_bmask_o=0011, rvalid_o stays 00.
REQ-037 Requester 1 holds lock_i=1 and req=1, requester 0 also requests -> 16 consecutive grants of 10, timeout, then gnt_o=01.
REQ-038 rst_n driven low in the cycle after a granted read -> no rvalid; after release, req_i=10 is granted on the first edge.
